// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered one-hot decoder with three behaviours.
//   DIRECT : y = 1<<sel, one cycle after sel is sampled.
//   SCAN   : walks the slots 0..N-1 continuously. Each slot is held for
//            dwell+1 cycles.
//   SWEEP  : walks the slots 0..N-1 once after a start request, then
//            pulses done for one cycle.
// y is always either all-zero or exactly one-hot.
module onehot_scan_decoder #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic                    start,
  output logic [(2**SEL_W)-1:0]   y,
  output logic [SEL_W-1:0]        idx,
  output logic                    busy,
  output logic                    done
);

  localparam int N = 2**SEL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIR   = 2'd1,
    SCAN  = 2'd2,
    SWEEP = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [N-1:0]       y_reg, y_next;
  logic [SEL_W-1:0]   idx_reg, idx_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [DWELL_W-1:0] shadow_reg, shadow_next;

  // Per-cycle decisions. Exactly one of these is taken on any given cycle.
  logic   slot_end;
  logic   do_idle;
  logic   do_dir;
  logic   do_enter;
  logic   do_advance;
  logic   do_finish;
  state_t enter_state;

  // Decide which transition happens this cycle, in priority order.
  always_comb begin
    do_idle     = 1'b0;
    do_dir      = 1'b0;
    do_enter    = 1'b0;
    do_advance  = 1'b0;
    do_finish   = 1'b0;
    enter_state = SCAN;
    slot_end    = (cnt_reg == shadow_reg);
    if (!en) begin
      do_idle = 1'b1;
    end else begin
      case (mode)
        2'b00: do_dir = 1'b1;
        2'b01: begin
          if (state_reg == SCAN) begin
            do_advance = 1'b1;
          end else begin
            do_enter = 1'b1;
          end
        end
        2'b10: begin
          if (state_reg == SWEEP) begin
            // The sweep finishes when the last slot's hold time has expired.
            if (slot_end && (&idx_reg)) begin
              do_finish = 1'b1;
            end else begin
              do_advance = 1'b1;
            end
          end else if ((state_reg == IDLE) && start) begin
            do_enter    = 1'b1;
            enter_state = SWEEP;
          end else begin
            do_idle = 1'b1;
          end
        end
        default: do_idle = 1'b1;
      endcase
    end
  end

  // Compute the next value of the state and of every registered output.
  always_comb begin
    state_next  = state_reg;
    y_next      = y_reg;
    idx_next    = idx_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    cnt_next    = cnt_reg;
    shadow_next = shadow_reg;
    if (do_idle || do_finish) begin
      state_next = IDLE;
      y_next     = '0;
      idx_next   = '0;
      busy_next  = 1'b0;
      cnt_next   = '0;
      done_next  = do_finish;
    end else if (do_dir) begin
      state_next  = DIR;
      y_next      = '0;
      y_next[sel] = 1'b1;
      idx_next    = sel;
      busy_next   = 1'b0;
      cnt_next    = '0;
    end else if (do_enter) begin
      state_next  = enter_state;
      y_next      = '0;
      y_next[0]   = 1'b1;
      idx_next    = '0;
      busy_next   = 1'b1;
      cnt_next    = '0;
      shadow_next = dwell;
    end else if (do_advance) begin
      if (slot_end) begin
        // Rotating y keeps it one-hot and in step with idx, including the
        // wrap from slot N-1 back to slot 0.
        y_next      = {y_reg[N-2:0], y_reg[N-1]};
        idx_next    = idx_reg + SEL_W'(1);
        cnt_next    = '0;
        shadow_next = dwell;
      end else begin
        cnt_next = cnt_reg + DWELL_W'(1);
      end
    end
  end

  // Register the state and all outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      y_reg      <= '0;
      idx_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
      shadow_reg <= '0;
    end else begin
      state_reg  <= state_next;
      y_reg      <= y_next;
      idx_reg    <= idx_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      cnt_reg    <= cnt_next;
      shadow_reg <= shadow_next;
    end
  end

  assign y    = y_reg;
  assign idx  = idx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: doc/onehot_scan_decoder.md
ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

Interface
REQ-001 The block SHALL take parameter SEL_W, default 4, meaning select width; output count N = 2**SEL_W.
REQ-002 The block SHALL take parameter DWELL_W, default 8, meaning dwell-counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port list, one per line:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  global enable.
- mode  input  2  00 DIRECT, 01 SCAN, 10 SWEEP, 11 reserved.
- sel  input  SEL_W  select index for DIRECT mode.
- dwell  input  DWELL_W  slot hold count minus one for SCAN and SWEEP.
- start  input  1  SWEEP trigger, level-sampled.
- y  output  N  registered one-hot output, or all-zero.
- idx  output  SEL_W  index of the active slot.
- busy  output  1  high while SCAN or SWEEP is running.
- done  output  1  one-cycle pulse at SWEEP completion.

Function
REQ-005 All outputs SHALL be registered; y SHALL be either all-zero or exactly one-hot, with no other pattern in any cycle.
REQ-006 The FSM SHALL have states IDLE, DIR, SCAN and SWEEP.
REQ-007 Transitions SHALL be evaluated every cycle, in this priority order:
- en=0 -> IDLE.
- mode=00 -> DIR.
- mode=01 -> SCAN.
- mode=10 -> SWEEP, entered from IDLE only when start=1; otherwise remain IDLE.
- mode=11 -> IDLE.
REQ-008 In IDLE: y=0, idx=0, busy=0, dwell counter=0.
REQ-009 In DIR (1-cycle latency): y = 1<<sel and idx = sel, both registered from the sel value of the previous cycle.
REQ-010 SCAN/SWEEP entry: in the cycle after entry, y=1<<0, idx=0, busy=1, dwell counter=0, and dwell is latched into a shadow register.
REQ-011 Slot hold: the counter increments each cycle. When counter equals the shadow dwell:
- counter clears;
- idx advances by 1;
- dwell is re-latched.
Each slot is therefore held shadow_dwell+1 cycles; dwell=0 gives a 1-cycle slot.
REQ-012 SCAN SHALL wrap idx from N-1 to 0 with no gap cycle and run until mode or en changes.
REQ-013 SWEEP completion: when slot N-1 expires, the next cycle SHALL have y=0, idx=0, busy=0, done=1 for exactly one cycle, and the FSM returns to IDLE.
REQ-014 start asserted while in SWEEP SHALL be ignored; start held high at completion SHALL retrigger a sweep only after one IDLE cycle.
REQ-015 A mode change or en deassertion mid-SCAN/SWEEP SHALL abort the sequence:
- no done pulse;
- counter clears;
- the new state takes effect on the next cycle per REQ-007 to REQ-010.
REQ-016 done SHALL be 0 in every cycle except the one in REQ-013.
REQ-017 The dwell input changing mid-slot SHALL NOT affect the current slot length.

Reset
REQ-018 While rst=1, the block SHALL hold state IDLE, y=0, idx=0, busy=0, done=0, counter=0 and shadow dwell=0, asynchronously.
REQ-019 After rst deasserts, the first state update SHALL occur on the next rising clk edge.
REQ-020 Reset asserted mid-SWEEP SHALL produce no done pulse.

Verification (SEL_W=4, DWELL_W=8)
REQ-021 DIRECT test: en=1, mode=00, sel=4'hA -> next cycle y=16'h0400, idx=10, busy=0; then sel=4'h3 -> next cycle y=16'h0008.
REQ-022 SCAN dwell=0 test: en=1, mode=01, dwell=0 -> y steps 0001, 0002, ... 8000, 0001 on consecutive cycles (wrap at cycle 17), busy=1 throughout, done never high.
REQ-023 SWEEP dwell=2 test: mode=10, start pulse -> each slot held 3 cycles for 48 cycles total, then one cycle with y=0 and done=1, then IDLE.
REQ-024 Abort test: SWEEP dwell=5 with en dropped during slot 7 -> next cycle y=0, busy=0, done=0; re-enable with mode=01 -> the scan restarts at idx=0.
REQ-025 Dwell-change test: SCAN dwell=3, dwell changed to 0 mid-slot -> the current slot still lasts 4 cycles and the following slots last 1 cycle.
REQ-026 Reset test: rst asserted asynchronously mid-SCAN between clock edges -> y=0 and busy=0 immediately; exhaustive check that y is always one-hot or zero.
